// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I datapath types, ABI register indices and ALU
//               operation encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA   = 5'd1;
  localparam reg_idx_t REG_SP   = 5'd2;
  localparam reg_idx_t REG_GP   = 5'd3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_sel_t;

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : 32 x XLEN integer register file, two ALU read ports, one
//               debug read port, one synchronous write port, write counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
  import riscv_pkg::*;
#(
  parameter int               XLEN    = riscv_pkg::XLEN,
  parameter int               NREGS   = riscv_pkg::NREGS,
  parameter logic [XLEN-1:0]  SP_INIT = 32'h0000_0FFC,
  parameter logic [XLEN-1:0]  GP_INIT = 32'h0000_0800
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [$clog2(NREGS)-1:0]  RS1_ADDR,
  input  logic [$clog2(NREGS)-1:0]  RS2_ADDR,
  input  logic [$clog2(NREGS)-1:0]  RD_ADDR,
  input  logic [XLEN-1:0]           WRITE_DATA,
  input  logic                      REG_WEN,
  input  logic [$clog2(NREGS)-1:0]  DBG_ADDR,
  output logic [XLEN-1:0]           BUS_A,
  output logic [XLEN-1:0]           BUS_B,
  output logic [XLEN-1:0]           DBG_DATA,
  output logic [15:0]               WRITE_COUNT
);

  localparam int c_aw = $clog2(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [15:0]     r_write_count;
  logic            w_wr_en;

  assign w_wr_en = REG_WEN && (RD_ADDR != c_aw'(REG_ZERO));

  // Entry 0 is reset but never written; reads of x0 are masked regardless.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[REG_SP] <= SP_INIT;
      r_regs[REG_GP] <= GP_INIT;
      r_write_count  <= '0;
    end else if (w_wr_en) begin
      r_regs[RD_ADDR] <= WRITE_DATA;
      r_write_count   <= r_write_count + 16'd1;
    end
  end

  // No write bypass: WRITE_DATA is derived from these buses in the datapath.
  assign BUS_A    = (RS1_ADDR == c_aw'(REG_ZERO)) ? '0 : r_regs[RS1_ADDR];
  assign BUS_B    = (RS2_ADDR == c_aw'(REG_ZERO)) ? '0 : r_regs[RS2_ADDR];
  assign DBG_DATA = (DBG_ADDR == c_aw'(REG_ZERO)) ? '0 : r_regs[DBG_ADDR];

  assign WRITE_COUNT = r_write_count;

  a_rd_addr_known : assert property (
    @(posedge CLK) disable iff (RESET) REG_WEN |-> !$isunknown(RD_ADDR)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module      : tb_reg_file
// Description : Randomised self-checking bench for reg_file against an
//               array-based architectural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reg_file;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] write_data = '0;
  logic        reg_wen = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic [31:0] dbg_data;
  logic [15:0] write_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model: what the ISA says the registers hold.
  logic [31:0] model [32];
  int          model_count = 0;

  reg_file dut (
    .CLK         (clk),
    .RESET       (rst),
    .RS1_ADDR    (rs1_addr),
    .RS2_ADDR    (rs2_addr),
    .RD_ADDR     (rd_addr),
    .WRITE_DATA  (write_data),
    .REG_WEN     (reg_wen),
    .DBG_ADDR    (dbg_addr),
    .BUS_A       (bus_a),
    .BUS_B       (bus_b),
    .DBG_DATA    (dbg_data),
    .WRITE_COUNT (write_count)
  );

  always #5 if (clk_run) clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'd0;
      model[2]    <= 32'h0000_0FFC;
      model[3]    <= 32'h0000_0800;
      model_count <= 0;
    end else if (reg_wen && rd_addr != 5'd0) begin
      model[rd_addr] <= write_data;
      model_count    <= (model_count + 1) % 65536;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wen, input logic [4:0] rd, input logic [31:0] data);
    reg_wen    = wen;
    rd_addr    = rd;
    write_data = data;
  endtask

  task automatic sweep_dbg(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #0.1;
      check(tag, dbg_data, (i == 0) ? 32'd0 : model[i]);
    end
    check({tag, "_count"}, {16'd0, write_count}, 32'(model_count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    sweep_dbg("por");
    rst = 1'b0;

    // Write then read x5
    drive(1'b1, 5'd5, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'd0);
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    check("x5_bus_a", bus_a, 32'hDEAD_BEEF);
    check("x5_bus_b", bus_b, 32'hDEAD_BEEF);
    check("x5_count", {16'd0, write_count}, 32'd1);

    // x0 immutability
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFF_FFFF);
    rs1_addr = 5'd0;
    @(posedge clk); #1;
    check("x0_bus_a", bus_a, 32'd0);
    check("x0_count", {16'd0, write_count}, 32'd1);

    // Same-cycle read/write of x7
    @(negedge clk);
    drive(1'b1, 5'd7, 32'd1);
    @(negedge clk);
    drive(1'b1, 5'd7, 32'd2);
    rs1_addr = 5'd7;
    #1;
    check("rw_before", bus_a, 32'd1);
    @(posedge clk); #1;
    check("rw_after", bus_a, 32'd2);
    check("rw_count", {16'd0, write_count}, 32'd3);

    // Reset colliding with a write to x9
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h1234_5678);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    dbg_addr = 5'd9;
    #0.1;
    check("coll_x9", dbg_data, 32'd0);
    check("coll_count", {16'd0, write_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive(($urandom % 4) != 0, 5'($urandom), $urandom);
      rs1_addr = 5'($urandom);
      rs2_addr = (($urandom % 8) == 0) ? rs1_addr : 5'($urandom);
      dbg_addr = 5'($urandom);
      #1;
      check("rnd_bus_a", bus_a, model[rs1_addr]);
      check("rnd_bus_b", bus_b, model[rs2_addr]);
      check("rnd_dbg", dbg_data, model[dbg_addr]);
      check("rnd_count", {16'd0, write_count}, 32'(model_count));
    end

    // Asynchronous reset with the clock stopped
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0);
    clk_run = 1'b0;
    #2 rst = 1'b1;
    #1;
    sweep_dbg("async_rst");
    check("async_rst_x2", dbg_data, dbg_data);  // self-compare, not counted
    n_checks--;
    dbg_addr = 5'd2; #0.1;
    check("async_rst_sp", dbg_data, 32'h0000_0FFC);
    dbg_addr = 5'd3; #0.1;
    check("async_rst_gp", dbg_data, 32'h0000_0800);
    rst = 1'b0;

    // Write-all sweep, first edge after reset release is honoured
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i * 4));
      clk_run = 1'b1;
      @(posedge clk); #1;
      dbg_addr = 5'(i);
      #0.1;
      check("sweep_dbg", dbg_data, 32'(i * 4));
      @(negedge clk);
    end
    drive(1'b0, 5'd0, 32'd0);
    dbg_addr = 5'd0;
    #1;
    check("sweep_x0", dbg_data, 32'd0);
    check("sweep_count", {16'd0, write_count}, 32'd31);
    sweep_dbg("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
